aes_key_schedule: RTL and testbench

Iterative AES-128 key-expansion engine that produces the eleven 128-bit round keys consumed by the round-key XOR stage, one key per accepted handshake. It sits directly upstream of the AddRoundKey stage and feeds its `Key` operand. It supports encryption order (rk0..rk10) and decryption order (rk10..rk0) from the same cipher key.

---
 rtl/aes_key_schedule_pkg.sv | 49 ++++
 rtl/aes_sbox_word.sv | 14 +
 rtl/aes_key_schedule.sv | 162 ++++++++++++++++
 tb/tb_aes_key_schedule.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_pkg.sv
// Shared AES-128 key-schedule constants: FSM states, Rcon, S-box table.
// Imported by aes_sbox_word and aes_key_schedule.
package aes_key_schedule_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRECOMP = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte n of the forward S-box sits at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon for a round index; out-of-range rounds contribute nothing.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r < 4'd10) v = RCON[r];
    return v;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four forward S-box lookups across a 32-bit word.
// Shared by the forward and inverse key-expansion steps.
module aes_sbox_word
  import aes_key_schedule_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar i = 0; i < 4; i++) begin : g_sb
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 round-key generator, forward or reverse order.
// Optional AES_KEY_CACHE_EN keeps all 11 keys to skip reverse precompute.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             decrypt,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_idx,
  output logic             rk_last
);

  logic [1:0]       state;
  logic             dir;
  logic [3:0]       idx;
  logic [KEY_W-1:0] wk;
  logic [KEY_W-1:0] nxt;
  logic [KEY_W-1:0] emit_nxt;
  logic [KEY_W-1:0] hit_key;
  logic             hit;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sb_in, sb_out, t;
  logic [3:0]       rc_idx;
  logic [3:0]       last_idx;
  logic             fwd_step;
  logic             xfer;

  assign {w0, w1, w2, w3} = wk;

  // PRECOMP always walks forward; EMIT follows the requested order.
  assign fwd_step = (state == PRECOMP) || !dir;

  // Reverse step needs w3 of the previous key, rebuilt as w3^w2.
  assign sb_in  = fwd_step ? w3 : (w3 ^ w2);
  assign rc_idx = fwd_step ? idx : (idx - 4'd1);

  aes_sbox_word u_sbox (
    .din  ({sb_in[23:0], sb_in[31:24]}),
    .dout (sb_out)
  );

  assign t = sb_out ^ {rcon(rc_idx), 24'h0};

  // One forward or inverse expansion step from the working key.
  always_comb begin
    nxt = '0;
    if (fwd_step) begin
      nxt[127:96] = w0 ^ t;
      nxt[95:64]  = w1 ^ nxt[127:96];
      nxt[63:32]  = w2 ^ nxt[95:64];
      nxt[31:0]   = w3 ^ nxt[63:32];
    end else begin
      nxt[127:96] = w0 ^ t;
      nxt[95:64]  = w1 ^ w0;
      nxt[63:32]  = w2 ^ w1;
      nxt[31:0]   = w3 ^ w2;
    end
  end

  assign busy     = (state != IDLE);
  assign rk_valid = (state == EMIT);
  assign rk_data  = wk;
  assign rk_idx   = idx;
  assign last_idx = dir ? 4'd0 : 4'(NR);
  assign rk_last  = rk_valid && (idx == last_idx);
  assign xfer     = rk_valid && rk_ready;

`ifdef AES_KEY_CACHE_EN
  logic [KEY_W-1:0] cache [0:NR];
  logic             cache_valid;
  logic             filling;
  logic             use_cache;
  logic [3:0]       rd_idx;

  assign hit      = cache_valid && (key_in == cache[0]);
  assign hit_key  = cache[NR];
  assign rd_idx   = (idx == 4'd0) ? 4'd0 : (idx - 4'd1);
  assign emit_nxt = use_cache ? cache[rd_idx] : nxt;

  // Cache bookkeeping: forward misses refill, reverse hits read back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      filling     <= 1'b0;
      use_cache   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        use_cache <= decrypt && hit;
        if (!decrypt && !hit) begin
          cache_valid <= 1'b0;
          filling     <= 1'b1;
        end
      end
      if (filling && state == EMIT && idx == 4'(NR)) begin
        cache_valid <= 1'b1;
        filling     <= 1'b0;
      end
    end
  end

  // Capture each forward key while it is on the output.
  always_ff @(posedge clk) begin
    if (rst_n && filling && state == EMIT) begin
      cache[idx] <= wk;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_key  = '0;
  assign emit_nxt = nxt;
`endif

  // Main sequencer: load, precompute for reverse, then emit on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dir   <= 1'b0;
      idx   <= '0;
      wk    <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            dir <= decrypt;
            if (decrypt && hit) begin
              wk    <= hit_key;
              idx   <= 4'(NR);
              state <= EMIT;
            end else begin
              wk    <= key_in;
              idx   <= '0;
              state <= decrypt ? PRECOMP : EMIT;
            end
          end
        end
        (state == PRECOMP): begin
          wk  <= nxt;
          idx <= idx + 4'd1;
          if (idx == 4'(NR - 1)) state <= EMIT;
        end
        (state == EMIT): begin
          if (xfer) begin
            if (rk_last) begin
              state <= IDLE;
            end else begin
              wk  <= emit_nxt;
              idx <= dir ? (idx - 4'd1) : (idx + 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a GF(2^8)-derived
// key-expansion model; works with or without AES_KEY_CACHE_EN.
module tb_aes_key_schedule;

`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         decrypt;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;

  int checks;
  int failures;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got [0:10];
  bit           cvalid;
  logic [127:0] ckey;

  aes_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .decrypt  (decrypt),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] p;
    logic [7:0] r1, r2, r3, r4;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        p = 8'h01;
        for (int j = 0; j < 254; j++) p = gmul(p, 8'(a));
        inv = p;
      end
      r1 = rotl1(inv);
      r2 = rotl1(r1);
      r3 = rotl1(r2);
      r4 = rotl1(r3);
      sb[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  // Textbook FIPS-197 word expansion into 11 round keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]],
               sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_last"}, 128'(rk_last), 128'(0));
    chk({tag, "_data"}, rk_data, 128'(0));
    chk({tag, "_idx"}, 128'(rk_idx), 128'(0));
  endtask

  // One complete schedule; optional mid-run start pulse or reset at idx 4.
  task automatic run_seq(input logic [127:0] key, input bit dec,
                         input int pready, input int poke_at,
                         input bit do_rst);
    int cyc;
    int first;
    int k;
    int lat;
    int e;
    bit done;
    bit poked;
    expand(key);
    lat = 1;
    if (dec) lat = (CACHE && cvalid && key == ckey) ? 1 : 11;
    if (!dec && !(cvalid && key == ckey)) cvalid = 1'b0;
    @(negedge clk);
    key_in   = key;
    decrypt  = dec;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    key_in = ~key;
    cyc   = 1;
    first = 0;
    k     = 0;
    done  = 1'b0;
    poked = 1'b0;
    while (!done && cyc < 200) begin
      start = 1'b0;
      if (rk_valid) begin
        if (first == 0) begin
          first = cyc;
          chk("latency", 128'(first), 128'(lat));
        end
        e = dec ? 10 - k : k;
        got[e] = rk_data;
        chk("rk_data", rk_data, exp_rk[e]);
        chk("rk_idx", 128'(rk_idx), 128'(e));
        chk("rk_last", 128'(rk_last), 128'(k == 10));
        if (poke_at == e && !poked) begin
          poked   = 1'b1;
          start   = 1'b1;
          key_in  = key ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
          decrypt = ~dec;
        end
        if (do_rst && e == 4) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk_reset_outputs("midrst");
          cvalid = 1'b0;
          return;
        end
        rk_ready = ($urandom_range(99) < pready);
        if (rk_ready) begin
          k++;
          done = (k == 11);
        end
      end else begin
        chk("busy_wait", 128'(busy), 128'(1));
        if (first != 0) chk("valid_drop", 128'(rk_valid), 128'(1));
        rk_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("complete", 128'(done), 128'(1));
    chk("busy_end", 128'(busy), 128'(0));
    chk("valid_end", 128'(rk_valid), 128'(0));
    if (pready >= 100) chk("throughput", 128'(cyc - first), 128'(11));
    if (!dec && done) begin
      cvalid = 1'b1;
      ckey   = key;
    end
    decrypt = 1'b0;
  endtask

  initial begin
    logic [127:0] rkey;
    logic [127:0] bkey;
    checks   = 0;
    failures = 0;
    cvalid   = 1'b0;
    ckey     = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    decrypt  = 1'b0;
    rk_ready = 1'b0;
    build_sbox();

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_seq(FIPS_KEY, 1'b0, 100, -1, 1'b0);
    chk("fips_rk0", got[0], FIPS_KEY);
    chk("fips_rk1", got[1], FIPS_RK1);
    chk("fips_rk10", got[10], FIPS_RK10);

    run_seq(FIPS_KEY, 1'b1, 100, -1, 1'b0);
    chk("fips_rev_rk10", got[10], FIPS_RK10);
    chk("fips_rev_rk0", got[0], FIPS_KEY);

    for (int n = 0; n < 6; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_seq(rkey, 1'($urandom_range(1)), 50, -1, 1'b0);
    end

    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, 1'b0, 50, -1, 1'b0);
    run_seq(rkey, 1'b1, 50, -1, 1'b0);

    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, 1'b0, 100, 5, 1'b0);
    run_seq(rkey, 1'b1, 70, 5, 1'b0);

    run_seq(FIPS_KEY, 1'b0, 100, -1, 1'b1);
    run_seq(FIPS_KEY, 1'b0, 100, -1, 1'b0);
    chk("post_rst_rk0", got[0], FIPS_KEY);

    rkey = {$urandom, $urandom, $urandom, $urandom};
    bkey = {$urandom, $urandom, $urandom, $urandom};
    run_seq(rkey, 1'b0, 100, -1, 1'b0);
    run_seq(bkey, 1'b1, 100, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
